serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that reuses a single one-bit full-adder cell over WIDTH clock cycles, LSB first, to add two WIDTH-bit operands plus a carry-in.
- Gives the full-adder datapath a start/busy/done handshake so higher-level blocks can sequence multi-bit additions with minimal area.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high in RUN and DONE states
- done  output  1  single-cycle pulse; result valid
- sum  output  WIDTH  result; holds last value until next accepted start
- cout  output  1  final carry-out; holds like sum
- sub  input  1  present only when SERIAL_ADDER_SUB_EN is defined (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry flop and bit counter are also cleared.
- IDLE:
  - busy=0.
  - start=1 loads a_sh<=a, b_sh<=b, carry<=cin and cnt<=0, then moves to RUN.
  - start=0 leaves the state at IDLE.
- RUN:
  - Each cycle the full-adder cell takes (a_sh[0], b_sh[0], carry).
  - The cell's sum bit shifts into sum from the MSB side (sum <= {s, sum[WIDTH-1:1]}).
  - carry <= cell carry-out; a_sh and b_sh shift right by 1; cnt increments.
  - When cnt==WIDTH-1, the cycle's carry-out is written to cout and the state moves to DONE.
- DONE: done=1 for exactly one cycle, then the state returns to IDLE unconditionally.
- Latency: if start is accepted at edge 0, the last bit is computed at edge WIDTH and done is high during the cycle after edge WIDTH. Issue interval is WIDTH+2 cycles per operation.
- sum is not valid while busy, because it shifts during RUN. Consumers sample it when done=1 or afterwards.
- start during RUN or DONE is ignored. It is not queued and operands are not recaptured.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- Counter: cnt is $clog2(WIDTH) bits and never wraps past WIDTH-1.
- Reset mid-operation: the operation is aborted immediately, all outputs return to reset values, and no done pulse is generated.
- Arithmetic: the result is modulo 2^WIDTH, with the overflow carry in cout. No signed interpretation.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Input port sub exists and is captured on accepted start.
  - sub=1: b_sh loads ~b and carry loads 1 (cin ignored), giving a-b. cout=1 means no borrow.
  - sub=0: addition, as above.
- Not defined: port sub is absent and the block is add-only. Behaviour is identical to the sub=0 case.

Decomposition:
- Package serial_adder_pkg contains:
  - state enum typedef (IDLE, RUN, DONE);
  - STATE_W constant;
  - CNT_W helper function ($clog2 wrapper).
- Sub-module fa_cell: a purely combinational 1-bit full adder (inputs x, y, ci; outputs s, co), instantiated once.
- The FSM, shift registers and counter stay in serial_adder_ctrl.

Test Plan (WIDTH=8):
- a=0x5A, b=0x33, cin=0, start pulse at edge 0 -> done high after edge 8, sum=0x8D, cout=0; busy high edges 1-9.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then start with a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0 (clears prior result).
- a=0x12, b=0x34 started. At edge 3, start=1 with a=0xFF, b=0xFF -> ignored; result sum=0x46, cout=0; exactly one done pulse.
- a=0x80, b=0x80 started. rst asserted asynchronously mid-cycle at edge 4 -> busy=0, sum=0, cout=0 immediately, no done. After release, a=0x01, b=0x02 -> sum=0x03.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1.
  - sub=1, a=0x01, b=0x02 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bit counter width; at least one bit even for degenerate widths.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder reused every cycle by the serial adder.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per operation.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' input (a - b via ~b and carry-in 1).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned      CntW    = cnt_w(WIDTH);
    localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0]   b_load;
    logic               carry_load;
    logic               fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    fa_cell u_fa_cell (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                if (cnt_q == CntLast) begin
                    cout_d  = fa_co;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
